// File: rtl/ps2_pkg.sv
// Shared PS/2 protocol constants, controller state encoding and small
// classification helpers for the keyboard host controller.
package ps2_pkg;

   localparam logic [7:0] CMD_RESET   = 8'hFF;
   localparam logic [7:0] CMD_SET_LED = 8'hED;
   localparam logic [7:0] RSP_ACK     = 8'hFA;
   localparam logic [7:0] RSP_RESEND  = 8'hFE;
   localparam logic [7:0] RSP_BAT_OK  = 8'hAA;
   localparam logic [7:0] RSP_BAT_ERR = 8'hFC;
   localparam logic [7:0] SC_BREAK    = 8'hF0;
   localparam logic [7:0] SC_EXT      = 8'hE0;

   localparam logic [7:0] SC_CAPS     = 8'h58;
   localparam logic [7:0] SC_NUM      = 8'h77;
   localparam logic [7:0] SC_SCROLL   = 8'h7E;

   typedef enum logic [3:0] {
      ST_RST_TX      = 4'd0,
      ST_RST_ACK     = 4'd1,
      ST_BAT_WAIT    = 4'd2,
      ST_IDLE        = 4'd3,
      ST_LED_CMD     = 4'd4,
      ST_LED_CMD_ACK = 4'd5,
      ST_LED_DAT     = 4'd6,
      ST_LED_DAT_ACK = 4'd7,
      ST_ERROR       = 4'd8
   } state_t;

   function automatic logic is_send(input state_t s);
      case (s)
         ST_RST_TX, ST_LED_CMD, ST_LED_DAT: is_send = 1'b1;
         default:                           is_send = 1'b0;
      endcase
   endfunction

   function automatic logic is_ack(input state_t s);
      case (s)
         ST_RST_ACK, ST_LED_CMD_ACK, ST_LED_DAT_ACK: is_ack = 1'b1;
         default:                                    is_ack = 1'b0;
      endcase
   endfunction

   function automatic state_t ack_of(input state_t s);
      case (s)
         ST_RST_TX:  ack_of = ST_RST_ACK;
         ST_LED_CMD: ack_of = ST_LED_CMD_ACK;
         ST_LED_DAT: ack_of = ST_LED_DAT_ACK;
         default:    ack_of = s;
      endcase
   endfunction

   function automatic state_t send_of(input state_t s);
      case (s)
         ST_RST_ACK:     send_of = ST_RST_TX;
         ST_LED_CMD_ACK: send_of = ST_LED_CMD;
         ST_LED_DAT_ACK: send_of = ST_LED_DAT;
         default:        send_of = s;
      endcase
   endfunction

   function automatic state_t after_ack(input state_t s);
      case (s)
         ST_RST_ACK:     after_ack = ST_BAT_WAIT;
         ST_LED_CMD_ACK: after_ack = ST_LED_DAT;
         ST_LED_DAT_ACK: after_ack = ST_IDLE;
         default:        after_ack = s;
      endcase
   endfunction

   function automatic logic is_response(input logic [7:0] b);
      is_response = (b == RSP_ACK) || (b == RSP_RESEND) ||
                    (b == RSP_BAT_OK) || (b == RSP_BAT_ERR);
   endfunction

endpackage

// File: rtl/ps2_cmd_timer.sv
// Loadable down-counter shared by the ACK and BAT waits; expired is a
// registered strobe high in the single cycle the count sits at zero.
module ps2_cmd_timer #(
   parameter int W = 26
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         clear,
   input  logic [W-1:0] load_val,
   output logic         expired
);

   logic [W-1:0] cnt;
   logic         active;

   // Count down from the loaded value and flag the zero cycle once.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt     <= '0;
         active  <= 1'b0;
         expired <= 1'b0;
      end else begin
         expired <= 1'b0;
         if (load) begin
            cnt     <= load_val;
            active  <= 1'b1;
            expired <= (load_val == '0);
         end else if (clear) begin
            cnt    <= '0;
            active <= 1'b0;
         end else if (active) begin
            if (cnt == '0) begin
               active <= 1'b0;
            end else begin
               cnt     <= cnt - W'(1);
               expired <= (cnt == W'(1));
            end
         end
      end
   end

endmodule

// File: rtl/ps2_kbd_ctrl.sv
// PS/2 keyboard host controller: reset/BAT handshake, lock-key LED
// sequencing with resend and timeout handling, and scancode filtering.
module ps2_kbd_ctrl
   import ps2_pkg::*;
#(
   parameter int ACK_TIMEOUT = 1_000_000,
   parameter int BAT_TIMEOUT = 50_000_000,
   parameter int MAX_RETRY   = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       reinit,
   input  logic       rx_valid,
   input  logic [7:0] rx_data,
   output logic       tx_start,
   output logic [7:0] tx_data,
   input  logic       tx_busy,
   input  logic       tx_done,
   input  logic       tx_err,
   output logic       out_valid,
   output logic [7:0] out_data,
   output logic [2:0] led_state,
   output logic       kbd_ready,
   output logic       kbd_err
);

   localparam int TW = $clog2(BAT_TIMEOUT + 1);
   localparam int RW = $clog2(MAX_RETRY + 2);

   state_t        state;
   state_t        eff;
   logic          sent;
   logic [RW-1:0] retry;
   logic          led_pending;
   logic          brk;

   logic          in_send;
   logic          tx_ok;
   logic          tx_fail;
   logic          rx_ack;
   logic          rx_resend;
   logic          consume;
   logic          retry_exhausted;
   logic [2:0]    lock_mask;
   logic [7:0]    send_byte;

   logic          timer_load;
   logic          timer_clr;
   logic [TW-1:0] timer_val;
   logic          expired;

   // A tx_done completes the send first, so a byte in the same cycle is
   // judged against the ACK state it leads to.
   always_comb begin
      in_send         = is_send(state);
      tx_ok           = in_send && sent && tx_done;
      if (tx_ok) begin
         eff = ack_of(state);
      end else begin
         eff = state;
      end
      tx_fail         = tx_err && (is_ack(state) || (in_send && sent));
      rx_ack          = rx_valid && (rx_data == RSP_ACK);
      rx_resend       = rx_valid && (rx_data == RSP_RESEND);
      consume         = rx_valid && is_response(rx_data) &&
                        (is_ack(eff) || (eff == ST_BAT_WAIT));
      retry_exhausted = (int'(retry) >= MAX_RETRY);
   end

   // Lock-key decode and the byte each send state transmits.
   always_comb begin
      case (rx_data)
         SC_CAPS:   lock_mask = 3'b100;
         SC_NUM:    lock_mask = 3'b010;
         SC_SCROLL: lock_mask = 3'b001;
         default:   lock_mask = 3'b000;
      endcase
      case (state)
         ST_RST_TX:  send_byte = CMD_RESET;
         ST_LED_CMD: send_byte = CMD_SET_LED;
         ST_LED_DAT: send_byte = {5'b00000, led_state};
         default:    send_byte = 8'h00;
      endcase
   end

   // Timer control: BAT window opens on the reset ACK, ACK window on tx_done.
   always_comb begin
      timer_load = 1'b0;
      timer_val  = '0;
      timer_clr  = reinit || !(is_ack(state) || (state == ST_BAT_WAIT));
      if (reinit) begin
         timer_load = 1'b0;
      end else if ((eff == ST_RST_ACK) && rx_ack) begin
         timer_load = 1'b1;
         timer_val  = TW'(BAT_TIMEOUT - 1);
      end else if (tx_ok) begin
         timer_load = 1'b1;
         timer_val  = TW'(ACK_TIMEOUT - 1);
      end else begin
         timer_load = 1'b0;
      end
   end

   ps2_cmd_timer #(
      .W(TW)
   ) u_timer (
      .clk     (clk),
      .rst     (rst),
      .load    (timer_load),
      .clear   (timer_clr),
      .load_val(timer_val),
      .expired (expired)
   );

   // Controller FSM with registered outputs, filtering and lock tracking.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_RST_TX;
         sent        <= 1'b0;
         retry       <= '0;
         led_pending <= 1'b0;
         brk         <= 1'b0;
         tx_start    <= 1'b0;
         tx_data     <= 8'h00;
         out_valid   <= 1'b0;
         out_data    <= 8'h00;
         led_state   <= 3'b000;
         kbd_ready   <= 1'b0;
         kbd_err     <= 1'b0;
      end else if (reinit) begin
         state       <= ST_RST_TX;
         sent        <= 1'b0;
         retry       <= '0;
         led_pending <= 1'b0;
         brk         <= 1'b0;
         tx_start    <= 1'b0;
         out_valid   <= 1'b0;
         led_state   <= 3'b000;
         kbd_ready   <= 1'b0;
         kbd_err     <= 1'b0;
      end else begin
         tx_start  <= 1'b0;
         out_valid <= 1'b0;

         if ((state != ST_ERROR) && rx_valid && !consume) begin
            out_valid <= 1'b1;
            out_data  <= rx_data;
         end

         if (state == ST_ERROR) begin
            kbd_err   <= 1'b1;
            kbd_ready <= 1'b0;
         end else if (in_send && !sent) begin
            if (!tx_busy) begin
               tx_start <= 1'b1;
               tx_data  <= send_byte;
               sent     <= 1'b1;
            end
         end else begin
            case (eff)
               ST_RST_ACK, ST_LED_CMD_ACK, ST_LED_DAT_ACK: begin
                  if (rx_ack) begin
                     retry <= '0;
                     sent  <= 1'b0;
                     state <= after_ack(eff);
                     if (eff == ST_LED_CMD_ACK) begin
                        led_pending <= 1'b0;
                     end
                     if (eff == ST_LED_DAT_ACK) begin
                        kbd_ready <= 1'b1;
                     end
                  end else if (rx_resend || tx_fail) begin
                     if (retry_exhausted) begin
                        state     <= ST_ERROR;
                        kbd_err   <= 1'b1;
                        kbd_ready <= 1'b0;
                     end else begin
                        retry <= retry + RW'(1);
                        sent  <= 1'b0;
                        state <= send_of(eff);
                     end
                  end else if (expired && !tx_ok) begin
                     state     <= ST_ERROR;
                     kbd_err   <= 1'b1;
                     kbd_ready <= 1'b0;
                  end else if (tx_ok) begin
                     state <= eff;
                  end
               end
               ST_BAT_WAIT: begin
                  if (rx_valid && (rx_data == RSP_BAT_OK)) begin
                     state     <= ST_LED_CMD;
                     sent      <= 1'b0;
                     led_state <= 3'b000;
                  end else if ((rx_valid && (rx_data == RSP_BAT_ERR)) || expired) begin
                     state     <= ST_ERROR;
                     kbd_err   <= 1'b1;
                     kbd_ready <= 1'b0;
                  end
               end
               ST_IDLE: begin
                  if (led_pending) begin
                     state <= ST_LED_CMD;
                     sent  <= 1'b0;
                  end
               end
               default: begin
                  if (tx_fail) begin
                     if (retry_exhausted) begin
                        state     <= ST_ERROR;
                        kbd_err   <= 1'b1;
                        kbd_ready <= 1'b0;
                     end else begin
                        retry <= retry + RW'(1);
                        sent  <= 1'b0;
                     end
                  end
               end
            endcase
         end

         // Placed last so a toggle in the LED_DAT entry cycle keeps pending set.
         if (rx_valid && (state != ST_ERROR)) begin
            if (rx_data == SC_BREAK) begin
               brk <= 1'b1;
            end else if (rx_data != SC_EXT) begin
               if (brk) begin
                  brk <= 1'b0;
               end else if (lock_mask != 3'b000) begin
                  led_state   <= led_state ^ lock_mask;
                  led_pending <= 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Scenario bench for ps2_kbd_ctrl: forwarded bytes go through a queue
// scoreboard, transmitted bytes and status are checked inline per scenario.
module tb_ps2_kbd_ctrl;

   logic       clk = 1'b0;
   logic       rst, reinit, rx_valid, tx_busy, tx_done, tx_err;
   logic [7:0] rx_data;
   logic       tx_start, out_valid, kbd_ready, kbd_err;
   logic [7:0] tx_data, out_data;
   logic [2:0] led_state;

   int         vectors     = 0;
   int         miscompares = 0;
   int         tx_count    = 0;
   logic [7:0] exp_q[$];
   logic [7:0] exp_head;

   always #5 clk = ~clk;

   ps2_kbd_ctrl #(
      .ACK_TIMEOUT(16),
      .BAT_TIMEOUT(64),
      .MAX_RETRY  (3)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .reinit   (reinit),
      .rx_valid (rx_valid),
      .rx_data  (rx_data),
      .tx_start (tx_start),
      .tx_data  (tx_data),
      .tx_busy  (tx_busy),
      .tx_done  (tx_done),
      .tx_err   (tx_err),
      .out_valid(out_valid),
      .out_data (out_data),
      .led_state(led_state),
      .kbd_ready(kbd_ready),
      .kbd_err  (kbd_err)
   );

   // Scoreboard for forwarded bytes plus the tx_start-while-busy rule.
   always @(negedge clk) begin
      if (out_valid) begin
         vectors++;
         if (exp_q.size() == 0) begin
            $display("FAIL out_stream: got out_data=%h, required no output", out_data);
            miscompares++;
         end else begin
            exp_head = exp_q.pop_front();
            if (out_data !== exp_head) begin
               $display("FAIL out_stream: got out_data=%h, required %h", out_data, exp_head);
               miscompares++;
            end
         end
      end
      if (tx_start) begin
         tx_count++;
         vectors++;
         if (tx_busy !== 1'b0) begin
            $display("FAIL tx_start_busy: got tx_busy=%b with tx_start, required 0", tx_busy);
            miscompares++;
         end
      end
   end

   task automatic rx_byte(input logic [7:0] b, input bit fwd);
      @(posedge clk); #1;
      rx_valid = 1'b1;
      rx_data  = b;
      if (fwd) exp_q.push_back(b);
      @(posedge clk); #1;
      rx_valid = 1'b0;
   endtask

   task automatic wait_tx_start(output bit found, output logic [7:0] d);
      found = 1'b0;
      d     = 8'h00;
      for (int i = 0; i < 200 && !found; i++) begin
         @(negedge clk);
         if (tx_start === 1'b1) begin
            found = 1'b1;
            d     = tx_data;
         end
      end
   endtask

   task automatic finish_tx();
      @(posedge clk); #1;
      tx_busy = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      tx_busy = 1'b0;
      tx_done = 1'b1;
      @(posedge clk); #1;
      tx_done = 1'b0;
   endtask

   task automatic send_and_ack(input logic [7:0] exp, input string nm);
      bit         f;
      logic [7:0] d;
      wait_tx_start(f, d);
      vectors++;
      if (!f || d !== exp) begin
         $display("FAIL %s: got tx_data=%h (seen=%0d), required %h", nm, d, f, exp);
         miscompares++;
      end
      finish_tx();
      rx_byte(8'hFA, 1'b0);
   endtask

   task automatic test_reset();
      rst = 1'b1; reinit = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
      tx_busy = 1'b0; tx_done = 1'b0; tx_err = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      vectors += 7;
      if (tx_start !== 1'b0)     begin $display("FAIL rst_tx_start: got %b, required 0", tx_start); miscompares++; end
      if (tx_data !== 8'h00)     begin $display("FAIL rst_tx_data: got %h, required 00", tx_data); miscompares++; end
      if (out_valid !== 1'b0)    begin $display("FAIL rst_out_valid: got %b, required 0", out_valid); miscompares++; end
      if (out_data !== 8'h00)    begin $display("FAIL rst_out_data: got %h, required 00", out_data); miscompares++; end
      if (led_state !== 3'b000)  begin $display("FAIL rst_led: got %b, required 000", led_state); miscompares++; end
      if (kbd_ready !== 1'b0)    begin $display("FAIL rst_ready: got %b, required 0", kbd_ready); miscompares++; end
      if (kbd_err !== 1'b0)      begin $display("FAIL rst_err: got %b, required 0", kbd_err); miscompares++; end
   endtask

   task automatic test_init();
      @(posedge clk); #1;
      rst = 1'b0;
      send_and_ack(8'hFF, "init_reset_cmd");
      @(negedge clk);
      vectors++;
      if (kbd_ready !== 1'b0) begin $display("FAIL init_ready_early: got %b, required 0", kbd_ready); miscompares++; end
      rx_byte(8'hAA, 1'b0);
      send_and_ack(8'hED, "init_led_cmd");
      send_and_ack(8'h00, "init_led_data");
      @(negedge clk);
      vectors += 3;
      if (kbd_ready !== 1'b1)   begin $display("FAIL init_ready: got %b, required 1", kbd_ready); miscompares++; end
      if (led_state !== 3'b000) begin $display("FAIL init_led: got %b, required 000", led_state); miscompares++; end
      if (kbd_err !== 1'b0)     begin $display("FAIL init_err: got %b, required 0", kbd_err); miscompares++; end
   endtask

   task automatic test_caps();
      int base;
      @(posedge clk); #1;
      rx_valid = 1'b1; rx_data = 8'h58; exp_q.push_back(8'h58);
      @(negedge clk);
      vectors++;
      if (out_valid !== 1'b0) begin $display("FAIL caps_out_early: got %b, required 0", out_valid); miscompares++; end
      @(posedge clk); #1;
      rx_valid = 1'b0;
      @(negedge clk);
      vectors++;
      if (out_valid !== 1'b1 || out_data !== 8'h58) begin
         $display("FAIL caps_out_latency: got valid=%b data=%h, required 1/58", out_valid, out_data); miscompares++;
      end
      send_and_ack(8'hED, "caps_led_cmd");
      send_and_ack(8'h04, "caps_led_data");
      @(negedge clk);
      vectors++;
      if (led_state !== 3'b100) begin $display("FAIL caps_led: got %b, required 100", led_state); miscompares++; end
      base = tx_count;
      rx_byte(8'hF0, 1'b1);
      rx_byte(8'hE0, 1'b1);
      rx_byte(8'h58, 1'b1);
      repeat (20) @(negedge clk);
      vectors++;
      if (tx_count != base || led_state !== 3'b100) begin
         $display("FAIL caps_break: got tx=%0d led=%b, required tx=%0d led=100", tx_count, led_state, base); miscompares++;
      end
   endtask

   task automatic test_toggle_during_seq();
      bit         f;
      logic [7:0] d;
      int         base;
      rx_byte(8'h58, 1'b1);
      send_and_ack(8'hED, "caps_off_cmd");
      send_and_ack(8'h00, "caps_off_data");
      rx_byte(8'h58, 1'b1);
      wait_tx_start(f, d);
      vectors++;
      if (!f || d !== 8'hED) begin $display("FAIL tog_cmd: got %h (seen=%0d), required ED", d, f); miscompares++; end
      finish_tx();
      rx_byte(8'h77, 1'b1);
      rx_byte(8'hFA, 1'b0);
      send_and_ack(8'h06, "tog_merged_data");
      base = tx_count;
      repeat (30) @(negedge clk);
      vectors++;
      if (tx_count != base || led_state !== 3'b110) begin
         $display("FAIL tog_no_second: got tx=%0d led=%b, required tx=%0d led=110", tx_count, led_state, base); miscompares++;
      end
      rx_byte(8'h7E, 1'b1);
      send_and_ack(8'hED, "late_cmd");
      wait_tx_start(f, d);
      vectors++;
      if (!f || d !== 8'h07) begin $display("FAIL late_data: got %h (seen=%0d), required 07", d, f); miscompares++; end
      rx_byte(8'h7E, 1'b1);
      finish_tx();
      rx_byte(8'hFA, 1'b0);
      send_and_ack(8'hED, "late_second_cmd");
      send_and_ack(8'h06, "late_second_data");
      @(negedge clk);
      vectors++;
      if (led_state !== 3'b110) begin $display("FAIL late_led: got %b, required 110", led_state); miscompares++; end
   endtask

   task automatic test_same_cycle();
      bit         f;
      logic [7:0] d;
      rx_byte(8'h7E, 1'b1);
      wait_tx_start(f, d);
      vectors++;
      if (!f || d !== 8'hED) begin $display("FAIL same_cmd: got %h (seen=%0d), required ED", d, f); miscompares++; end
      @(posedge clk); #1;
      tx_busy = 1'b1;
      @(posedge clk); #1;
      tx_busy = 1'b0; tx_done = 1'b1; rx_valid = 1'b1; rx_data = 8'hFA;
      @(posedge clk); #1;
      tx_done = 1'b0; rx_valid = 1'b0;
      send_and_ack(8'h07, "same_data");
      @(negedge clk);
      vectors++;
      if (kbd_ready !== 1'b1 || led_state !== 3'b111) begin
         $display("FAIL same_state: got ready=%b led=%b, required 1/111", kbd_ready, led_state); miscompares++;
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] seq [5] = '{8'h1C, 8'h32, 8'h21, 8'hFA, 8'hAA};
      @(posedge clk); #1;
      for (int i = 0; i < 5; i++) begin
         rx_valid = 1'b1; rx_data = seq[i]; exp_q.push_back(seq[i]);
         @(posedge clk); #1;
      end
      rx_valid = 1'b0;
      repeat (3) @(negedge clk);
      vectors++;
      if (exp_q.size() != 0) begin $display("FAIL b2b_drain: got %0d bytes left, required 0", exp_q.size()); miscompares++; end
   endtask

   task automatic test_resend();
      bit         f;
      logic [7:0] d;
      int         base;
      rx_byte(8'h58, 1'b1);
      wait_tx_start(f, d);
      vectors++;
      if (!f || d !== 8'hED) begin $display("FAIL resend_first: got %h (seen=%0d), required ED", d, f); miscompares++; end
      finish_tx();
      for (int i = 0; i < 3; i++) begin
         rx_byte(8'hFE, 1'b0);
         wait_tx_start(f, d);
         vectors++;
         if (!f || d !== 8'hED) begin $display("FAIL resend_%0d: got %h (seen=%0d), required ED", i, d, f); miscompares++; end
         finish_tx();
      end
      rx_byte(8'hFE, 1'b0);
      @(negedge clk);
      vectors++;
      if (kbd_err !== 1'b1 || kbd_ready !== 1'b0) begin
         $display("FAIL resend_error: got err=%b ready=%b, required 1/0", kbd_err, kbd_ready); miscompares++;
      end
      base = tx_count;
      rx_byte(8'h1C, 1'b0);
      rx_byte(8'h58, 1'b0);
      repeat (20) @(negedge clk);
      vectors++;
      if (tx_count != base || led_state !== 3'b011 || kbd_err !== 1'b1) begin
         $display("FAIL error_quiet: got tx=%0d led=%b err=%b, required tx=%0d led=011 err=1",
                  tx_count, led_state, kbd_err, base); miscompares++;
      end
   endtask

   task automatic test_timeout();
      bit         f;
      logic [7:0] d;
      @(posedge clk); #1; reinit = 1'b1;
      @(posedge clk); #1; reinit = 1'b0;
      wait_tx_start(f, d);
      vectors += 2;
      if (!f || d !== 8'hFF) begin $display("FAIL reinit_tx: got %h (seen=%0d), required FF", d, f); miscompares++; end
      if (kbd_err !== 1'b0 || led_state !== 3'b000) begin
         $display("FAIL reinit_clear: got err=%b led=%b, required 0/000", kbd_err, led_state); miscompares++;
      end
      finish_tx();
      repeat (15) @(posedge clk);
      @(negedge clk);
      vectors++;
      if (kbd_err !== 1'b0) begin $display("FAIL timeout_early: got err=%b at cycle 15, required 0", kbd_err); miscompares++; end
      @(negedge clk);
      vectors++;
      if (kbd_err !== 1'b1) begin $display("FAIL timeout_at16: got err=%b at cycle 16, required 1", kbd_err); miscompares++; end
   endtask

   task automatic test_backpressure();
      bit         f;
      logic [7:0] d;
      int         base;
      @(posedge clk); #1; reinit = 1'b1; tx_busy = 1'b1;
      @(posedge clk); #1; reinit = 1'b0;
      base = tx_count;
      repeat (10) @(posedge clk);
      @(negedge clk);
      vectors++;
      if (tx_count != base) begin $display("FAIL bp_held: got %0d starts, required %0d", tx_count, base); miscompares++; end
      @(posedge clk); #1; tx_busy = 1'b0;
      wait_tx_start(f, d);
      vectors++;
      if (!f || d !== 8'hFF) begin $display("FAIL bp_start: got %h (seen=%0d), required FF", d, f); miscompares++; end
      @(negedge clk);
      vectors++;
      if (tx_start !== 1'b0) begin $display("FAIL bp_width: got tx_start=%b, required 0", tx_start); miscompares++; end
      finish_tx();
      rx_byte(8'hFA, 1'b0);
      rx_byte(8'hAA, 1'b0);
      send_and_ack(8'hED, "bp_led_cmd");
      send_and_ack(8'h00, "bp_led_data");
      @(negedge clk);
      vectors++;
      if (kbd_ready !== 1'b1 || kbd_err !== 1'b0) begin
         $display("FAIL bp_ready: got ready=%b err=%b, required 1/0", kbd_ready, kbd_err); miscompares++;
      end
   endtask

   initial begin
      test_reset();
      test_init();
      test_caps();
      test_toggle_during_seq();
      test_same_cycle();
      test_back_to_back();
      test_resend();
      test_timeout();
      test_backpressure();
      repeat (5) @(negedge clk);
      vectors++;
      if (exp_q.size() != 0) begin
         $display("FAIL out_drain: got %0d undelivered bytes, required 0", exp_q.size()); miscompares++;
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
